opsum_stream_buffer: RTL and testbench
======================================

OPSUM_STREAM_BUFFER -- requirements
Module: opsum_stream_buffer

Interface
REQ-001 SHALL have parameter ROW_NUM, default 32: reducer rows per entry.
REQ-002 SHALL have parameter DEPTH, default 4: entries stored, power of two, at least 2.
REQ-003 SHALL have parameter DATA_W, default 16: bits per row value.
REQ-004 SHALL have parameter BUS_W, default 32: GLB write-bus width; multiple of DATA_W; ROW_NUM*DATA_W divisible by BUS_W.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  in  1  synchronous clear of contents, pointers and error flag.
REQ-008 SHALL have port wr_valid  in  1  reducer entry offered.
REQ-009 SHALL have port wr_ready  out  1  entry accepted when wr_valid&&wr_ready.
REQ-010 SHALL have port wr_data  in  ROW_NUM*DATA_W  row r at bits [r*DATA_W +: DATA_W].
REQ-011 SHALL have port rd_valid  out  1  beat available to GLB.
REQ-012 SHALL have port rd_ready  in  1  GLB accepts beat.
REQ-013 SHALL have port rd_data  out  BUS_W  beat, lane k = row (beat*L+k), L=BUS_W/DATA_W.
REQ-014 SHALL have port rd_last  out  1  final beat of current entry.
REQ-015 SHALL have port level  out  $clog2(DEPTH+1)  entries held.
REQ-016 SHALL have port full, empty  out  1 each  level==DEPTH, level==0.
REQ-017 SHALL have port overflow_err  out  1  sticky: push attempted while full.

Function
REQ-018 SHALL store entries in a circular buffer with wr_ptr, rd_ptr, level; B=ROW_NUM/L beats per entry.
REQ-019 SHALL assert wr_ready = !full; no same-cycle bypass when full.
REQ-020 SHALL write wr_data to slot wr_ptr on push, wr_ptr wraps DEPTH-1 -> 0.
REQ-021 SHALL run drain FSM IDLE (empty) / STREAM (level>0); IDLE->STREAM when level becomes nonzero, STREAM->IDLE on popping last entry with no push that cycle.
REQ-022 SHALL assert rd_valid only in STREAM; rd_data selects beat beat_cnt of slot rd_ptr, registered-storage driven, stable while rd_valid && !rd_ready.
REQ-023 SHALL advance beat_cnt on rd_valid&&rd_ready; at beat_cnt==B-1 assert rd_last, reset beat_cnt to 0, pop entry, rd_ptr wraps.
REQ-024 SHALL keep level unchanged on simultaneous push and pop; first push into empty buffer gives rd_valid on the following cycle (1-cycle latency).
REQ-025 SHALL drop wr_valid while full without modifying storage and set overflow_err, held until flush or reset.
REQ-026 SHALL drive rd_data to zero when rd_valid is low.
REQ-027 SHALL give flush priority over push and pop in the same cycle: level=0, pointers=0, beat_cnt=0, FSM=IDLE, overflow_err=0.

Reset
REQ-028 SHALL on reset low, immediately: level=0, wr_ptr=rd_ptr=beat_cnt=0, FSM=IDLE, rd_valid=0, rd_last=0, rd_data=0, wr_ready=1, empty=1, full=0, overflow_err=0; storage contents need not be cleared.
REQ-029 SHALL abandon a partially drained entry on reset mid-stream; no beat resumes after release.

Configuration
REQ-030 SHALL compile in, with macro OPSUM_RELU_EN defined, per-lane ReLU on rd_data: lane treated as signed DATA_W, negative -> 0.
REQ-031 SHALL without OPSUM_RELU_EN pass lanes unmodified; handshake and timing identical in both builds.

Structure
REQ-032 SHALL place default parameter constants, lanes-per-beat/beats-per-entry helper functions and FSM state enum in shared package opsum_pkg.
REQ-033 SHALL use one sub-module opsum_beat_sel: combinational beat/lane mux plus optional ReLU.

Verification
REQ-034 SHALL cover: push row r = r+1 (defaults), rd_ready=1 -> 16 beats, beat 0 = 0x0002_0001, beat 15 = 0x0020_001F, rd_last on beat 15 only, empty after.
REQ-035 SHALL cover: 4 pushes with rd_ready=0 -> full=1, 5th push -> wr_ready=0, overflow_err=1, entries 0..3 drain intact in order.
REQ-036 SHALL cover: rd_ready toggling every cycle -> rd_data stable while stalled, 32 cycles per entry, no lost beats.
REQ-037 SHALL cover: level=3, simultaneous push and final-beat pop -> level stays 3, wr_ptr and rd_ptr both wrap correctly.
REQ-038 SHALL cover: reset low at beat 7 -> all outputs at reset values same cycle; flush with wr_valid high -> level=0, entry not stored.
REQ-039 SHALL cover: OPSUM_RELU_EN build, row 0 = 0xFFF0, row 1 = 0x0005 -> beat 0 = 0x0005_0000; without macro -> 0x0005_FFF0.

Source files
------------

// File: rtl/opsum_pkg.sv
// rtl/opsum_pkg.sv - shared defaults, beat geometry helpers and drain FSM states for the opsum stream buffer
package opsum_pkg;

  localparam int ROW_NUM_DEF = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int BUS_W_DEF   = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  function automatic int lanes_per_beat(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  function automatic int beats_per_entry(input int row_num, input int bus_w, input int data_w);
    return row_num / lanes_per_beat(bus_w, data_w);
  endfunction

  // Index width that stays at least one bit for single-element ranges
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opsum_beat_sel.sv
// rtl/opsum_beat_sel.sv - combinational beat/lane mux of one stored entry; OPSUM_RELU_EN clamps negative lanes to zero
module opsum_beat_sel
  import opsum_pkg::*;
#(
  parameter int ROW_NUM = ROW_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUS_W   = BUS_W_DEF,
  parameter int BEAT_W  = 4
) (
  input  logic [ROW_NUM*DATA_W-1:0] entry_i,
  input  logic [BEAT_W-1:0]         beat_i,
  input  logic                      valid_i,
  output logic [BUS_W-1:0]          data_o
);

  localparam int L = lanes_per_beat(BUS_W, DATA_W);

  logic [DATA_W-1:0] lane;

  always_comb begin
    data_o = '0;
    lane   = '0;
    if (valid_i) begin
      for (int k = 0; k < L; k++) begin
        lane = entry_i[(int'(beat_i) * L + k) * DATA_W +: DATA_W];
`ifdef OPSUM_RELU_EN
        if (lane[DATA_W-1]) lane = '0;
`else
        lane = lane;
`endif
        data_o[k*DATA_W +: DATA_W] = lane;
      end
    end
  end

endmodule

// File: rtl/opsum_stream_buffer.sv
// rtl/opsum_stream_buffer.sv - circular buffer of reducer entries drained as BUS_W beats to the GLB; OPSUM_RELU_EN enables lane ReLU
module opsum_stream_buffer
  import opsum_pkg::*;
#(
  parameter int ROW_NUM = ROW_NUM_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUS_W   = BUS_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ROW_NUM*DATA_W-1:0]    wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [BUS_W-1:0]             rd_data,
  output logic                         rd_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow_err
);

  localparam int B      = beats_per_entry(ROW_NUM, BUS_W, DATA_W);
  localparam int BEAT_W = idx_width(B);
  localparam int PTR_W  = idx_width(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic [ROW_NUM*DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  drain_state_e      state_q, state_d;

  logic push, pop;

  assign full         = (level_q == LVL_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign wr_ready     = !full;
  assign level        = level_q;
  assign overflow_err = ovf_q;
  assign rd_valid     = (state_q == ST_STREAM);
  assign rd_last      = rd_valid && (beat_q == BEAT_W'(B - 1));
  assign push         = wr_valid && !full;
  assign pop          = rd_valid && rd_ready && rd_last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (wr_valid && full);
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      beat_d   = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      state_d  = ST_IDLE;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_valid && rd_ready) begin
        if (rd_last) begin
          beat_d   = '0;
          rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // Draining continues whenever an entry remains, including a push that refills on the final pop
      state_d = (level_d != '0) ? ST_STREAM : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  opsum_beat_sel #(
    .ROW_NUM (ROW_NUM),
    .DATA_W  (DATA_W),
    .BUS_W   (BUS_W),
    .BEAT_W  (BEAT_W)
  ) u_beat_sel (
    .entry_i (mem_q[rd_ptr_q]),
    .beat_i  (beat_q),
    .valid_i (rd_valid),
    .data_o  (rd_data)
  );

endmodule

// File: tb/tb_opsum_stream_buffer.sv
// tb/tb_opsum_stream_buffer.sv - scoreboard bench for opsum_stream_buffer with a queue-based reference model
module tb_opsum_stream_buffer;

  localparam int ROW_NUM = 32;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 16;
  localparam int BUS_W   = 32;
  localparam int L       = BUS_W / DATA_W;
  localparam int B       = ROW_NUM / L;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       flush = 1'b0;
  logic                       wr_valid = 1'b0;
  logic                       rd_ready = 1'b0;
  logic [ROW_NUM*DATA_W-1:0]  wr_data = '0;
  logic                       wr_ready, rd_valid, rd_last, full, empty, overflow_err;
  logic [BUS_W-1:0]           rd_data;
  logic [$clog2(DEPTH+1)-1:0] level;

  opsum_stream_buffer #(
    .ROW_NUM (ROW_NUM),
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .BUS_W   (BUS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [BUS_W-1:0] exp_data[$];
  logic             exp_last[$];
  int               model_cnt = 0;
  bit               model_ovf = 1'b0;
  bit               stall_pend = 1'b0;
  logic [BUS_W-1:0] stall_data;
  logic             stall_last;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef OPSUM_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [ROW_NUM*DATA_W-1:0] rand_entry();
    logic [ROW_NUM*DATA_W-1:0] v;
    for (int r = 0; r < ROW_NUM; r++) v[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_data.delete();
    exp_last.delete();
    model_cnt  = 0;
    model_ovf  = 1'b0;
    stall_pend = 1'b0;
  endtask

  // Monitor: mid-cycle sampling, compares against the entry-count model and beat queue
  always @(negedge clk) begin
    if (!reset || flush) begin
      model_clear();
    end else begin
      logic [BUS_W-1:0] w;
      chk("level", level, model_cnt);
      chk("full", full, model_cnt == DEPTH);
      chk("empty", empty, model_cnt == 0);
      chk("wr_ready", wr_ready, model_cnt < DEPTH);
      chk("rd_valid", rd_valid, model_cnt > 0);
      chk("overflow_err", overflow_err, model_ovf);
      if (!rd_valid) chk("rd_data_idle_zero", rd_data, 0);
      if (stall_pend && rd_valid) begin
        chk("stall_data_stable", rd_data, stall_data);
        chk("stall_last_stable", rd_last, stall_last);
      end
      if (rd_valid && rd_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual=%0h expected=none", rd_data);
        end else begin
          chk("beat_data", rd_data, exp_data.pop_front());
          chk("beat_last", rd_last, exp_last[0]);
          if (exp_last.pop_front()) model_cnt--;
        end
      end
      stall_pend = rd_valid && !rd_ready;
      stall_data = rd_data;
      stall_last = rd_last;
      if (wr_valid && (model_cnt + (rd_valid && rd_ready && 0) >= DEPTH + 1)) model_ovf = 1'b1;
      if (wr_valid && wr_ready) begin
        for (int b = 0; b < B; b++) begin
          for (int k = 0; k < L; k++) w[k*DATA_W +: DATA_W] = relu(wr_data[(b*L + k)*DATA_W +: DATA_W]);
          exp_data.push_back(w);
          exp_last.push_back(b == B - 1);
        end
        model_cnt++;
      end else if (wr_valid && !wr_ready) begin
        model_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [ROW_NUM*DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (!empty && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", empty, 1);
    rd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
  endtask

  initial begin
    logic [ROW_NUM*DATA_W-1:0] d;
    int n;

    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Ramp entry: row r holds r+1
    for (int r = 0; r < ROW_NUM; r++) d[r*DATA_W +: DATA_W] = DATA_W'(r + 1);
    push_entry(d);
    chk("first_push_latency", rd_valid, 1);
    chk("ramp_beat0", rd_data, 32'h0002_0001);
    chk("ramp_beat0_not_last", rd_last, 0);
    rd_ready = 1'b1;
    repeat (B - 1) tick();
    chk("ramp_beat15", rd_data, 32'h0020_001F);
    chk("ramp_beat15_last", rd_last, 1);
    tick();
    rd_ready = 1'b0;
    chk("ramp_empty_after", empty, 1);

    // Fill to full, then one overflowing push
    repeat (DEPTH) push_entry(rand_entry());
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = rand_entry();
    tick();
    wr_valid = 1'b0;
    chk("overflow_set", overflow_err, 1);
    chk("overflow_level", level, DEPTH);
    drain(200);
    chk("overflow_sticky", overflow_err, 1);

    // Level 3, then push in the same cycle as the final beat of the head entry
    repeat (3) push_entry(rand_entry());
    rd_ready = 1'b1;
    n = 0;
    while (!rd_last && n < 64) begin
      tick();
      n++;
    end
    chk("simul_found_last", rd_last, 1);
    wr_valid = 1'b1;
    wr_data  = rand_entry();
    tick();
    wr_valid = 1'b0;
    chk("simul_level", level, 3);
    drain(300);

    // Flush with a concurrent push
    push_entry(rand_entry());
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = rand_entry();
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow_err, 0);
    tick();
    chk("flush_not_stored", rd_valid, 0);

    // rd_ready toggling every cycle
    push_entry(rand_entry());
    n = 0;
    while (rd_valid && n < 100) begin
      n++;
      rd_ready = (n % 2 == 0);
      tick();
    end
    rd_ready = 1'b0;
    chk("toggle_cycles", n, 2 * B);

    // Negative and positive lanes
    d = rand_entry();
    d[0 +: DATA_W]      = 16'hFFF0;
    d[DATA_W +: DATA_W] = 16'h0005;
    push_entry(d);
`ifdef OPSUM_RELU_EN
    chk("relu_beat0", rd_data, 32'h0005_0000);
`else
    chk("relu_beat0", rd_data, 32'h0005_FFF0);
`endif
    drain(64);

    // Random traffic with occasional flush
    repeat (3000) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      rd_ready = $urandom_range(0, 1) == 1;
      wr_data  = rand_entry();
      flush    = ($urandom_range(0, 199) == 0);
      tick();
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    drain(300);

    // Reset in the middle of an entry at beat 7
    push_entry(rand_entry());
    rd_ready = 1'b1;
    repeat (7) tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("no_resume", rd_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
